muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers.
- Consumes the two register-file read operands (rs, rt) in the execute stage.
- Runs MULT/MULTU/DIV/DIVU over multiple cycles while the pipeline stalls on busy.
- Also services MTHI/MTLO in one cycle; hi/lo feed MFHI/MFLO back toward register-file writeback.

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
//   start   : request strobe, only honoured while busy is low
//   op      : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   rs_data : operand A (multiplicand / dividend / MTHI-MTLO source)
//   rt_data : operand B (multiplier / divisor)
//   busy    : arithmetic operation in flight, pipeline must stall
//   done    : one-cycle pulse when HI/LO were written by an arithmetic op
//   hi, lo  : architectural HI/LO registers
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
//   clk   : clock, all state changes on posedge
//   reset : synchronous, active-high; discards any in-flight operation
//   bus   : muldiv_unit_if slave (start/op/rs_data/rt_data in, busy/done/hi/lo out)
// Arithmetic ops take one accept edge, WIDTH iteration edges and one fix-up edge.
// Multiply is shift-add over unsigned magnitudes; divide is restoring shift-subtract.
// MTHI/MTLO write one register directly in a single cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  localparam logic [5:0] LastIter = 6'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  // Multiply: {partial high, remaining multiplier bits}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes; op[0]=0 selects the signed variants.
  logic             a_sign, b_sign;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_sign = ~bus.op[0] & bus.rs_data[WIDTH-1];
  assign b_sign = ~bus.op[0] & bus.rt_data[WIDTH-1];
  assign a_mag  = a_sign ? -bus.rs_data : bus.rs_data;
  assign b_mag  = b_sign ? -bus.rt_data : bus.rt_data;

  // One shift-add multiply step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;

  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

  // One restoring divide step. The remainder stays below the divisor, so the
  // shifted value fits in WIDTH+1 bits and the difference fits in WIDTH bits.
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff, rem_next;
  logic [2*WIDTH-1:0] div_step;

  assign rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
  assign rem_next = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
  assign div_step = {rem_next, prod_q[WIDTH-2:0], rem_ge};

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo, rem;

  assign prod_neg = -prod_q;
  assign quo      = prod_q[WIDTH-1:0];
  assign rem      = prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            OpMult, OpMultu: begin
              prod_d    = {{WIDTH{1'b0}}, b_mag};
              opnd_d    = a_mag;
              is_div_d  = 1'b0;
              neg_res_d = a_sign ^ b_sign;
              neg_rem_d = 1'b0;
              cnt_d     = '0;
              state_d   = StRun;
            end
            OpDiv, OpDivu: begin
              is_div_d = 1'b1;
              cnt_d    = '0;
              state_d  = StRun;
              opnd_d   = b_mag;
              if (bus.rt_data == '0) begin
                // Raw dividend and no sign fixup: iterating against a zero
                // divisor yields all-ones quotient and remainder = rs_data.
                prod_d    = {{WIDTH{1'b0}}, bus.rs_data};
                neg_res_d = 1'b0;
                neg_rem_d = 1'b0;
              end else begin
                prod_d    = {{WIDTH{1'b0}}, a_mag};
                neg_res_d = a_sign ^ b_sign;
                neg_rem_d = a_sign;
              end
            end
            OpMthi:  hi_d = bus.rs_data;
            OpMtlo:  lo_d = bus.rs_data;
            default: ;
          endcase
        end
      end
      StRun: begin
        prod_d = is_div_q ? div_step : mul_step;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = neg_res_q ? -quo : quo;
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prod_q    <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed expected values.
module tb_muldiv_unit;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam logic [2:0] OpNop   = 3'b110;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge; presents a request for exactly one edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called #1 after the accept edge. lat = edges until done is seen; the edge
  // on which done is high is lat+1 edges after the accept edge.
  task automatic wait_done(input string tag, output int lat, output int busy_cycles);
    lat         = 0;
    busy_cycles = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " done seen"}, 32'(bus.done), 32'd1);
  endtask

  task automatic run_arith(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int lat, bc;
    start_op(op, a, b);
    wait_done(tag, lat, bc);
    check({tag, " latency"}, 32'(lat + 1), 32'd34);
    check({tag, " busy cycles"}, 32'(bc), 32'd33);
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    check({tag, " hi"}, bus.hi, exp_hi);
    check({tag, " lo"}, bus.lo, exp_lo);
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat, bc, dones, busies;
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OpNop;
    bus.rs_data = '0;
    bus.rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset hi", bus.hi, 32'h0);
    check("reset lo", bus.lo, 32'h0);

    run_arith("multu max", OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_arith("mult -3*7", OpMult, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_arith("div -7/2", OpDiv, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_arith("div 7/-2", OpDiv, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_arith("divu 100/0", OpDivu, 32'd100, 32'h0, 32'd100, 32'hFFFFFFFF);
    run_arith("div -5/0", OpDiv, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_arith("div min/-1", OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Single-cycle moves and a no-op request.
    start_op(OpMthi, 32'h12345678, 32'hDEADBEEF);
    check("mthi hi", bus.hi, 32'h12345678);
    check("mthi lo kept", bus.lo, 32'h80000000);
    check("mthi busy", 32'(bus.busy), 32'd0);
    check("mthi done", 32'(bus.done), 32'd0);
    start_op(OpMtlo, 32'h9ABCDEF0, 32'h0);
    check("mtlo lo", bus.lo, 32'h9ABCDEF0);
    check("mtlo hi kept", bus.hi, 32'h12345678);
    check("mtlo busy", 32'(bus.busy), 32'd0);
    check("mtlo done", 32'(bus.done), 32'd0);
    start_op(OpNop, 32'h11111111, 32'h22222222);
    check("nop hi", bus.hi, 32'h12345678);
    check("nop lo", bus.lo, 32'h9ABCDEF0);
    check("nop busy", 32'(bus.busy), 32'd0);

    // Request held while busy must be ignored: 100/7 -> q=14 r=2.
    start_op(OpDivu, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.op      = OpDivu;
    bus.rs_data = 32'd9;
    bus.rt_data = 32'd2;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignore busy", lat, bc);
    check("ignore busy latency", 32'(lat + 7), 32'd34);
    check("ignore busy hi", bus.hi, 32'd2);
    check("ignore busy lo", bus.lo, 32'd14);
    @(posedge clk);
    #1;
    check("ignore busy no restart", 32'(bus.busy), 32'd0);

    // Back-to-back: second start accepted on the edge where done is high.
    start_op(OpMultu, 32'd3, 32'd5);
    wait_done("b2b first", lat, bc);
    check("b2b first hi", bus.hi, 32'd0);
    check("b2b first lo", bus.lo, 32'd15);
    start_op(OpDivu, 32'd20, 32'd6);
    check("b2b second busy", 32'(bus.busy), 32'd1);
    wait_done("b2b second", lat, bc);
    check("b2b second latency", 32'(lat + 1), 32'd34);
    check("b2b second hi", bus.hi, 32'd2);
    check("b2b second lo", bus.lo, 32'd3);

    // Reset sampled on the edge performing iteration 10 of a DIVU.
    @(posedge clk);
    #1;
    start_op(OpDivu, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midop reset busy", 32'(bus.busy), 32'd0);
    check("midop reset done", 32'(bus.done), 32'd0);
    check("midop reset hi", bus.hi, 32'h0);
    check("midop reset lo", bus.lo, 32'h0);
    dones  = 0;
    busies = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
      if (bus.busy) busies++;
    end
    check("post-reset done pulses", 32'(dones), 32'd0);
    check("post-reset busy cycles", 32'(busies), 32'd0);
    check("post-reset hi", bus.hi, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
